// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer.
// Keeps a fetch PC, issues pipelined word reads over a valid/ready channel,
// buffers in-order responses in a DEPTH-entry FIFO and presents them to the
// core. A jump flushes the FIFO and marks all in-flight responses for discard.

// Protocol checker: a response with nothing outstanding, and a FIFO push
// into a full FIFO that is not popped or flushed in the same cycle.
module instr_prefetch_buf_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic rsp_orphan,
    input  logic fifo_overflow
);

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n) !rsp_orphan);

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n) !fifo_overflow);

endmodule

module instr_prefetch_buf #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jmp_en,
    input  logic [31:0] jmp_to,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] addr_instr
);

    localparam int unsigned CW  = $clog2(2 * DEPTH) + 1;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned TD  = 2 * DEPTH;
    localparam int unsigned TPW = $clog2(TD);
    localparam logic [31:0]   NOP_C  = 32'h0000_0013;
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_r;
    state_e        state_next_s;

    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] occ_r;
    logic [CW-1:0] outst_r;
    logic [CW-1:0] drop_r;

    logic [31:0]   ifq_data_r [DEPTH];
    logic [31:0]   ifq_addr_r [DEPTH];
    logic [PW-1:0] ifq_wr_ptr_r;
    logic [PW-1:0] ifq_rd_ptr_r;

    // Tags of requests in flight; dropped tags stay queued and pop unused.
    logic [31:0]    tag_r [TD];
    logic [TPW-1:0] tag_wr_ptr_r;
    logic [TPW-1:0] tag_rd_ptr_r;

    logic [CW-1:0] live_s;
    logic [CW-1:0] outst_next_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          rsp_ok_s;
    logic          rsp_drop_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   jmp_tgt_s;
    logic          rsp_orphan_s;
    logic          fifo_overflow_s;

    // Handshake decode and credit check
    always_comb begin
        live_s          = outst_r - drop_r;
        req_valid_s     = (state_r == ST_RUN)
                          && ((occ_r + live_s) < CW'(DEPTH))
                          && (outst_r < CW'(MAX_OUTST));
        req_fire_s      = req_valid_s && mem_req_ready;
        rsp_ok_s        = mem_rsp_valid && (outst_r != ZERO_C);
        rsp_drop_s      = rsp_ok_s && (drop_r != ZERO_C);
        push_s          = rsp_ok_s && !rsp_drop_s;
        pop_s           = (occ_r != ZERO_C) && instr_ready;
        outst_next_s    = outst_r + CW'(req_fire_s) - CW'(rsp_ok_s);
        jmp_tgt_s       = jmp_to & 32'hFFFF_FFFC;
        rsp_orphan_s    = mem_rsp_valid && (outst_r == ZERO_C);
        fifo_overflow_s = push_s && !pop_s && !jmp_en && (occ_r == CW'(DEPTH));
    end

    // Output drive: request from fetch PC, FIFO head or NOP when empty
    always_comb begin
        mem_req_valid = req_valid_s;
        mem_req_addr  = fetch_pc_r;
        instr_valid   = (occ_r != ZERO_C);
        if (occ_r != ZERO_C) begin
            instr_out  = ifq_data_r[ifq_rd_ptr_r];
            addr_instr = ifq_addr_r[ifq_rd_ptr_r];
        end else begin
            instr_out  = NOP_C;
            addr_instr = 32'h0000_0000;
        end
    end

    // Next state: BOOT lasts exactly one cycle, RUN is held until reset
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: state_next_s = ST_RUN;
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_BOOT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fetch PC: redirect wins over the post-fire increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
        end else if (jmp_en) begin
            fetch_pc_r <= jmp_tgt_s;
        end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Outstanding, discard and fill counters; a flush turns everything in flight into discards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_r <= ZERO_C;
            drop_r  <= ZERO_C;
            occ_r   <= ZERO_C;
        end else begin
            outst_r <= outst_next_s;
            if (jmp_en) begin
                drop_r <= outst_next_s;
                occ_r  <= ZERO_C;
            end else begin
                drop_r <= drop_r - CW'(rsp_drop_s);
                occ_r  <= occ_r + CW'(push_s) - CW'(pop_s);
            end
        end
    end

    // Instruction FIFO pointers; a flush empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifq_wr_ptr_r <= {PW{1'b0}};
            ifq_rd_ptr_r <= {PW{1'b0}};
        end else if (jmp_en) begin
            ifq_wr_ptr_r <= {PW{1'b0}};
            ifq_rd_ptr_r <= {PW{1'b0}};
        end else begin
            ifq_wr_ptr_r <= ifq_wr_ptr_r + PW'(push_s);
            ifq_rd_ptr_r <= ifq_rd_ptr_r + PW'(pop_s);
        end
    end

    // Instruction FIFO storage: fetched word and its address at the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ifq_data_r[i] <= 32'h0000_0000;
                ifq_addr_r[i] <= 32'h0000_0000;
            end
        end else if (push_s && !jmp_en) begin
            ifq_data_r[ifq_wr_ptr_r] <= mem_rsp_data;
            ifq_addr_r[ifq_wr_ptr_r] <= tag_r[tag_rd_ptr_r];
        end else begin
            ifq_data_r <= ifq_data_r;
            ifq_addr_r <= ifq_addr_r;
        end
    end

    // Address tag FIFO: push on request fire, pop on every accepted response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr_ptr_r <= {TPW{1'b0}};
            tag_rd_ptr_r <= {TPW{1'b0}};
            for (int i = 0; i < int'(TD); i++) begin
                tag_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (req_fire_s) begin
                tag_r[tag_wr_ptr_r] <= fetch_pc_r;
            end else begin
                tag_r <= tag_r;
            end
            tag_wr_ptr_r <= tag_wr_ptr_r + TPW'(req_fire_s);
            tag_rd_ptr_r <= tag_rd_ptr_r + TPW'(rsp_ok_s);
        end
    end

    instr_prefetch_buf_chk u_chk (
        .clk           (clk),
        .rst_n         (rst_n),
        .rsp_orphan    (rsp_orphan_s),
        .fifo_overflow (fifo_overflow_s)
    );

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Testbench for instr_prefetch_buf: a queue-based reference model of the
// fetch buffer plus an in-order memory model, compared every cycle, with
// directed scenarios pinned by literal expectations and a randomized run.
module tb_instr_prefetch_buf;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jmp_en = 1'b0;
    logic [31:0] jmp_to = 32'h0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] addr_instr;

    instr_prefetch_buf #(
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jmp_en        (jmp_en),
        .jmp_to        (jmp_to),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .addr_instr    (addr_instr)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        mem_q[$];   // fired, not yet answered, oldest first
    logic [63:0] fifo_q[$];  // {addr, data} visible to the core
    logic [31:0] m_pc;
    bit          m_run;
    int          cyc;
    int          n_tests;
    int          n_fail;
    int          dut_fires;
    int          p_mready, p_iready, p_rsp, p_jmp, lat_min, lat_max;
    bit          got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: compare outputs, drive inputs, advance the model.
    task automatic cycle(input bit do_jmp, input logic [31:0] tgt);
        int          live;
        bit          exp_valid;
        bit          fire;
        bit          pop;
        bit          rsp;
        logic [31:0] rdata;
        logic [63:0] head;
        req_t        e;
        @(negedge clk);
        cyc++;
        live = 0;
        foreach (mem_q[i]) if (!mem_q[i].stale) live++;
        exp_valid = m_run && (fifo_q.size() + live < DEPTH) && (mem_q.size() < MAX_OUTST);
        chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_valid));
        chk("mem_req_addr", mem_req_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            head = fifo_q[0];
            chk("instr_out", instr_out, head[31:0]);
            chk("addr_instr", addr_instr, head[63:32]);
        end else begin
            chk("instr_out_empty", instr_out, NOP);
            chk("addr_instr_empty", addr_instr, 32'h0);
        end

        jmp_en        = do_jmp || ($urandom_range(99) < p_jmp);
        jmp_to        = do_jmp ? tgt : $urandom;
        mem_req_ready = ($urandom_range(99) < p_mready);
        instr_ready   = ($urandom_range(99) < p_iready);
        rsp           = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rsp);
        rdata         = $urandom;
        mem_rsp_valid = rsp;
        mem_rsp_data  = rdata;
        if (mem_req_valid && mem_req_ready) dut_fires++;

        fire = exp_valid && mem_req_ready;
        pop  = (fifo_q.size() != 0) && instr_ready;
        e    = '{addr: 32'h0, stale: 1'b1, due: 0};
        if (rsp) e = mem_q.pop_front();
        if (jmp_en) begin
            fifo_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        end else begin
            if (pop) void'(fifo_q.pop_front());
            if (rsp && !e.stale) fifo_q.push_back({e.addr, rdata});
        end
        if (fire) mem_q.push_back('{addr: m_pc, stale: jmp_en, due: cyc + int'($urandom_range(lat_max, lat_min))});
        if (jmp_en) m_pc = jmp_to & 32'hFFFF_FFFC;
        else if (fire) m_pc = m_pc + 32'd4;
    endtask

    // Reset pulse; the memory is reset together with the DUT.
    task automatic do_reset(input bit boot_jmp, input logic [31:0] tgt);
        @(negedge clk);
        rst_n         = 1'b0;
        jmp_en        = 1'b0;
        jmp_to        = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        instr_ready   = 1'b0;
        mem_q.delete();
        fifo_q.delete();
        m_pc  = RESET_PC;
        m_run = 1'b0;
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_req_addr", mem_req_addr, RESET_PC);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr_out", instr_out, NOP);
        chk("rst_addr_instr", addr_instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_req_valid", 32'(mem_req_valid), 32'h0);
        if (boot_jmp) begin
            jmp_en = 1'b1;
            jmp_to = tgt;
            m_pc   = tgt & 32'hFFFF_FFFC;
        end
        m_run = 1'b1;
    endtask

    task automatic wait_instr(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            cycle(1'b0, 32'h0);
            if (instr_valid) seen = 1'b1;
        end
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus sequence
    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; dut_fires = 0;
        m_pc = RESET_PC; m_run = 1'b0;
        p_mready = 100; p_iready = 100; p_rsp = 100; p_jmp = 0; lat_min = 1; lat_max = 1;

        // Streaming with a 1-cycle memory
        do_reset(1'b0, 32'h0);
        repeat (6) cycle(1'b0, 32'h0);
        chk("t1_addr_instr", addr_instr, 32'd12);
        chk("t1_req_addr", mem_req_addr, 32'd20);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0);
            chk("t1_valid_held", 32'(instr_valid), 32'h1);
        end

        // Core stalled: exactly DEPTH fires, then one pop gives one refill
        do_reset(1'b0, 32'h0);
        p_iready = 0; dut_fires = 0;
        repeat (20) cycle(1'b0, 32'h0);
        chk("t2_fires", 32'(dut_fires), 32'd4);
        chk("t2_req_valid_low", 32'(mem_req_valid), 32'h0);
        chk("t2_head", addr_instr, 32'h0);
        p_iready = 100; dut_fires = 0;
        cycle(1'b0, 32'h0);
        p_iready = 0;
        repeat (10) cycle(1'b0, 32'h0);
        chk("t2_refill_fires", 32'(dut_fires), 32'd1);
        chk("t2_head_after_pop", addr_instr, 32'd4);

        // 3-cycle memory, jump with 3 in flight
        do_reset(1'b0, 32'h0);
        p_iready = 100; lat_min = 3; lat_max = 3;
        repeat (3) cycle(1'b0, 32'h0);
        p_mready = 0; p_rsp = 0;
        cycle(1'b1, 32'h0000_0103);
        p_mready = 100; p_rsp = 100;
        cycle(1'b0, 32'h0);
        chk("t3_redirect_addr", mem_req_addr, 32'h0000_0100);
        chk("t3_flushed", 32'(instr_valid), 32'h0);
        wait_instr(20, got);
        chk("t3_valid_seen", 32'(got), 32'h1);
        chk("t3_first_addr", addr_instr, 32'h0000_0100);

        // Jump coinciding with fire, response and pop
        do_reset(1'b0, 32'h0);
        lat_min = 1; lat_max = 1;
        repeat (8) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0200);
        cycle(1'b0, 32'h0);
        chk("t4_flushed", 32'(instr_valid), 32'h0);
        chk("t4_redirect_addr", mem_req_addr, 32'h0000_0200);
        wait_instr(20, got);
        chk("t4_valid_seen", 32'(got), 32'h1);
        chk("t4_first_addr", addr_instr, 32'h0000_0200);

        // PC wrap at the top of the address space
        cycle(1'b1, 32'hFFFF_FFFF);
        cycle(1'b0, 32'h0);
        chk("t5_wrap_pre", mem_req_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0);
        chk("t5_wrap_post", mem_req_addr, 32'h0000_0000);

        // Reset mid-stream with 2 in flight
        lat_min = 2; lat_max = 2;
        repeat (6) cycle(1'b0, 32'h0);
        do_reset(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        chk("t6_restart_addr", mem_req_addr, RESET_PC);
        chk("t6_restart_valid", 32'(mem_req_valid), 32'h1);

        // Jump during BOOT, then randomized traffic
        do_reset(1'b1, 32'h0000_1237);
        cycle(1'b0, 32'h0);
        chk("t7_boot_jmp_addr", mem_req_addr, 32'h0000_1234);
        p_mready = 70; p_iready = 60; p_rsp = 70; p_jmp = 4; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            cycle(1'b0, 32'h0);
            if ($urandom_range(599) == 0) do_reset(1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
